// File: rtl/hazard_pkg.sv
// Shared defaults and constants for the decode-stage hazard scoreboard.
package hazard_pkg;
    localparam int NUM_REGS_DEF = 8;
    localparam int WB_DIST_DEF  = 3;
    // Link register that jal/jalr name as their destination.
    localparam logic [2:0] R7 = 3'd7;
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending-write countdown plus a load-producer flag.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int WB_DIST = WB_DIST_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic set_load,
    output logic busy,
    output logic in_ex,
    output logic is_load
);
    localparam int            CW      = $clog2(WB_DIST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WB_DIST);

    logic [CW-1:0] cnt;
    logic          ld;

    // A new producer overrides the countdown, so the newest writer always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ld  <= 1'b0;
        end else if (set) begin
            cnt <= CNT_MAX;
            ld  <= set_load;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy    = (cnt != '0);
    assign in_ex   = (cnt == CNT_MAX);
    assign is_load = ld;
endmodule

// File: rtl/hazard_scoreboard.sv
// Counter-based decode hazard unit: per-register pending writes, load-use
// detection, redirect flushes and saturating stall/flush statistics.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int WB_DIST  = WB_DIST_DEF,
    parameter int FWD_EN   = 1,
    parameter int PERF_W   = 16,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [RW-1:0]       id_src0,
    input  logic [RW-1:0]       id_src1,
    input  logic                id_src0_en,
    input  logic                id_src1_en,
    input  logic                id_src0_early,
    input  logic [RW-1:0]       id_dst,
    input  logic                id_dst_we,
    input  logic                id_is_load,
    input  logic                redirect,
    output logic                stall_decode,
    output logic                issue,
    output logic                flush_fetch,
    output logic                flush_decode,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [PERF_W-1:0]   stall_cnt,
    output logic [PERF_W-1:0]   flush_cnt
);
    logic [NUM_REGS-1:0] in_ex;
    logic [NUM_REGS-1:0] is_load;
    logic [NUM_REGS-1:0] set;
    logic                hazard0;
    logic                hazard1;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        assign set[g] = issue & id_dst_we & (id_dst == RW'(g));

        hazard_sb_entry #(.WB_DIST(WB_DIST)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .set     (set[g]),
            .set_load(id_is_load),
            .busy    (busy_mask[g]),
            .in_ex   (in_ex[g]),
            .is_load (is_load[g])
        );
    end

    // With forwarding, only a load still in EX blocks an EX-stage consumer;
    // a decode-stage consumer (jr/jalr base) must wait for writeback.
    always_comb begin
        hazard0 = 1'b0;
        hazard1 = 1'b0;
        if (id_src0_en) begin
            if (FWD_EN == 0 || id_src0_early) hazard0 = busy_mask[id_src0];
            else                              hazard0 = is_load[id_src0] & in_ex[id_src0];
        end
        if (id_src1_en) begin
            if (FWD_EN == 0) hazard1 = busy_mask[id_src1];
            else             hazard1 = is_load[id_src1] & in_ex[id_src1];
        end
    end

    // id_valid offers an instruction; issue is its acceptance. While
    // stall_decode is high decode holds its contents; redirect squashes them.
    assign stall_decode = id_valid & ~redirect & (hazard0 | hazard1);
    assign issue        = id_valid & ~redirect & ~stall_decode;
    assign flush_fetch  = redirect;
    assign flush_decode = redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_decode && stall_cnt != '1) stall_cnt <= stall_cnt + PERF_W'(1);
            if (redirect && flush_cnt != '1)     flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: three configurations share one
// stimulus stream and are checked against a ready-time reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_src0 = '0, id_src1 = '0, id_dst = '0;
    logic       id_src0_en = 1'b0, id_src1_en = 1'b0, id_src0_early = 1'b0;
    logic       id_dst_we = 1'b0, id_is_load = 1'b0, redirect = 1'b0;

    logic        stall0, issue0, ff0, fd0, stall1, issue1, ff1, fd1, stall2, issue2, ff2, fd2;
    logic [7:0]  bm0, bm1, bm2;
    logic [15:0] sc0, fc0, sc2, fc2;
    logic [3:0]  sc1, fc1;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(8), .WB_DIST(3), .FWD_EN(1), .PERF_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src0(id_src0), .id_src1(id_src1),
        .id_src0_en(id_src0_en), .id_src1_en(id_src1_en), .id_src0_early(id_src0_early),
        .id_dst(id_dst), .id_dst_we(id_dst_we), .id_is_load(id_is_load), .redirect(redirect),
        .stall_decode(stall0), .issue(issue0), .flush_fetch(ff0), .flush_decode(fd0),
        .busy_mask(bm0), .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_scoreboard #(.NUM_REGS(8), .WB_DIST(3), .FWD_EN(0), .PERF_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src0(id_src0), .id_src1(id_src1),
        .id_src0_en(id_src0_en), .id_src1_en(id_src1_en), .id_src0_early(id_src0_early),
        .id_dst(id_dst), .id_dst_we(id_dst_we), .id_is_load(id_is_load), .redirect(redirect),
        .stall_decode(stall1), .issue(issue1), .flush_fetch(ff1), .flush_decode(fd1),
        .busy_mask(bm1), .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_scoreboard #(.NUM_REGS(8), .WB_DIST(8), .FWD_EN(0), .PERF_W(16)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src0(id_src0), .id_src1(id_src1),
        .id_src0_en(id_src0_en), .id_src1_en(id_src1_en), .id_src0_early(id_src0_early),
        .id_dst(id_dst), .id_dst_we(id_dst_we), .id_is_load(id_is_load), .redirect(redirect),
        .stall_decode(stall2), .issue(issue2), .flush_fetch(ff2), .flush_decode(fd2),
        .busy_mask(bm2), .stall_cnt(sc2), .flush_cnt(fc2));

    wire [63:0] obs0 = {20'b0, stall0, issue0, ff0, fd0, bm0, sc0, fc0};
    wire [63:0] obs1 = {20'b0, stall1, issue1, ff1, fd1, bm1, 12'b0, sc1, 12'b0, fc1};
    wire [63:0] obs2 = {20'b0, stall2, issue2, ff2, fd2, bm2, sc2, fc2};

    // ---------------- reference model ----------------
    // A register is pending until its ready cycle; a load is in EX exactly
    // one cycle after it issued.
    int t = 0;
    int rdy   [NI][8];
    int iss_t [NI][8];
    bit mld   [NI][8];
    int m_sc  [NI];
    int m_fc  [NI];

    function automatic int fwd_of(int i);  return (i == 0) ? 1 : 0;  endfunction
    function automatic int wbd_of(int i);  return (i == 2) ? 8 : 3;  endfunction
    function automatic int pw_of(int i);   return (i == 1) ? 4 : 16; endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < 8; r++) begin
                rdy[i][r] = 0; iss_t[i][r] = -100; mld[i][r] = 1'b0;
            end
            m_sc[i] = 0; m_fc[i] = 0;
        end
    endfunction

    function automatic logic [63:0] predict(int i, bit upd);
        logic [7:0]  bm;
        logic [63:0] ret;
        bit h0, h1, st, is;
        int sat;
        for (int r = 0; r < 8; r++) bm[r] = (t < rdy[i][r]);
        h0 = id_src0_en && ((fwd_of(i) == 0 || id_src0_early) ? bm[id_src0]
                            : (mld[i][id_src0] && t == iss_t[i][id_src0] + 1));
        h1 = id_src1_en && ((fwd_of(i) == 0) ? bm[id_src1]
                            : (mld[i][id_src1] && t == iss_t[i][id_src1] + 1));
        st = id_valid && !redirect && (h0 || h1);
        is = id_valid && !redirect && !st;
        ret = {20'b0, st, is, redirect, redirect, bm, 16'(m_sc[i]), 16'(m_fc[i])};
        if (upd) begin
            sat = (1 << pw_of(i)) - 1;
            if (st && m_sc[i] < sat) m_sc[i]++;
            if (redirect && m_fc[i] < sat) m_fc[i]++;
            if (is && id_dst_we) begin
                rdy[i][id_dst]   = t + 1 + wbd_of(i);
                iss_t[i][id_dst] = t;
                mld[i][id_dst]   = id_is_load;
            end
        end
        return ret;
    endfunction

    // ---------------- scoreboard ----------------
    logic [NI*64-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [NI*64-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("inst0_fwd_outputs", obs0, e[63:0]);
            check("inst1_nofwd_outputs", obs1, e[127:64]);
            check("inst2_wb8_outputs", obs2, e[191:128]);
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input bit v, input logic [2:0] s0, input bit e0, input bit early,
                         input logic [2:0] s1, input bit e1, input logic [2:0] d,
                         input bit w, input bit l, input bit rd, input bit r);
        logic [NI*64-1:0] e;
        @(posedge clk); #1;
        rst = r; id_valid = v; id_src0 = s0; id_src0_en = e0; id_src0_early = early;
        id_src1 = s1; id_src1_en = e1; id_dst = d; id_dst_we = w; id_is_load = l;
        redirect = rd;
        if (r) model_reset();
        for (int i = 0; i < NI; i++) e[i*64 +: 64] = predict(i, !r);
        exp_q.push_back(e);
        t++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic probe();
        @(negedge clk); #1;
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // add r1 ; add r2,r1,r3 held in decode
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (5) cycle(1, 1, 1, 0, 3, 1, 2, 1, 0, 0, 0);
        probe(); check("nofwd_dep_stalls", 64'(sc1), 64'd3);
        idle(10);

        // ld r4 ; add r5,r4,r4
        cycle(1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        repeat (3) cycle(1, 4, 1, 0, 4, 1, 5, 1, 0, 0, 0);
        probe(); check("load_use_stalls", 64'(sc0), 64'd1);
        idle(6);
        cycle(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        repeat (2) cycle(1, 4, 1, 0, 4, 1, 5, 1, 0, 0, 0);
        probe(); check("alu_fwd_no_stall", 64'(sc0), 64'd1);
        idle(6);

        // jal ; jr r7 (early source)
        cycle(1, 0, 0, 0, 0, 0, R7, 1, 0, 0, 0);
        repeat (4) cycle(1, R7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        probe(); check("jr_early_stalls", 64'(sc0), 64'd4);
        check("r7_clear_on_issue", 64'(bm0[7]), 64'd0);
        idle(6);

        // redirect while stalled on r1
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 2, 1, 0, 1, 0);
        repeat (4) cycle(1, 1, 1, 0, 0, 0, 2, 1, 0, 0, 0);
        probe(); check("redirect_flush_cnt", 64'(fc0), 64'd1);
        idle(6);

        // WAW: ld r2 ; add r2 ; consumer of r2
        cycle(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 2, 1, 3, 1, 0, 0, 0);
        probe(); check("waw_newest_wins", 64'(sc0), 64'd4);
        idle(10);

        // fill every entry, then reset asynchronously mid-cycle
        for (int r = 0; r < 8; r++) cycle(1, 0, 0, 0, 0, 0, 3'(r), 1, 0, 0, 0);
        idle(1);
        probe(); check("busy_all", 64'(bm2), 64'hFF);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1; check("async_rst_busy", 64'(bm2), 64'h0);
        check("async_rst_stall_cnt", 64'(sc2), 64'h0);
        idle(2);

        // self-dependent chain to saturate the 4-bit stall counter
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (28) cycle(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        probe(); check("perf_saturate", 64'(sc1), 64'd15);

        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        end
        idle(2);
        probe();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised, counter-based hazard unit for the decode stage; successor to the fixed 3-bit, two-stage-compare stall logic.
- Keeps one pending-write countdown per architectural register, so any number of stages between decode and writeback is handled by one parameter.
- Supports a forwarding and a non-forwarding mode, tracks load producers separately for load-use stalls, and issues fetch/decode flushes on redirect.
- Keeps saturating stall and flush statistics counters.

## Interface

Parameters:
- `NUM_REGS`, 8: architectural registers; register index width is `RW = $clog2(NUM_REGS)`.
- `WB_DIST`, 3: cycles from issue until the destination is readable in decode; must be ≥1.
- `FWD_EN`, 1: 1 = EX/MEM forwarding present, so only load-use and early-source hazards stall. 0 = stall on any pending source.
- `PERF_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: the only clock; rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode holds a real instruction.
- `id_src0`, `id_src1` in RW: source register indices.
- `id_src0_en`, `id_src1_en` in 1: the source is actually read.
- `id_src0_early` in 1: src0 is consumed in decode (jr/jalr base), not in EX.
- `id_dst` in RW: destination index; jal/jalr drive 7, stu/lbi/slbi drive Rs.
- `id_dst_we` in 1: the instruction writes `id_dst`.
- `id_is_load` in 1: the producer is a load.
- `redirect` in 1: taken branch/jump resolved this cycle.
- `stall_decode` out 1: hold IF/ID and PC; insert a bubble into ID/EX.
- `issue` out 1: the decode instruction advances this cycle.
- `flush_fetch` out 1: squash IF/ID.
- `flush_decode` out 1: squash the instruction currently in decode.
- `busy_mask` out NUM_REGS: bit r set while `cnt[r] != 0`.
- `stall_cnt`, `flush_cnt` out PERF_W: saturating statistics.

## Operation

- Per-register state: `cnt[r]` (width `$clog2(WB_DIST+1)`) and `ld[r]` (1 bit).
- Every cycle, each nonzero `cnt` decrements by 1.
- On `issue & id_dst_we`: `cnt[id_dst] <= WB_DIST` and `ld[id_dst] <= id_is_load`. This overrides the decrement for that entry.
- WAW rule: reissuing to a pending register overwrites the entry; the newest producer wins.
- Hazard for an enabled source s:
  - `FWD_EN=0`: hazard when `cnt[s] != 0`.
  - `FWD_EN=1`, normal source: hazard when `ld[s] & cnt[s] == WB_DIST`, i.e. the load is in EX.
  - `FWD_EN=1`, early src0: hazard when `cnt[s] != 0`.
- `stall_decode = id_valid & ~redirect & (hazard0 | hazard1)`.
- `issue = id_valid & ~redirect & ~stall_decode`.
- `flush_fetch = flush_decode = redirect`. Redirect wins over stall; a squashed instruction never writes the scoreboard.
- Entries of producers already past decode are unaffected by redirect; they still write back.
- `stall_cnt` increments on each `stall_decode` cycle and `flush_cnt` on each `redirect` cycle; both saturate at all-ones.

## Timing

- All outputs are combinational from registered state plus this cycle's inputs; scoreboard updates take effect at the next edge.
- Reset, asynchronous:
  - all `cnt` and `ld` are 0, `busy_mask = 0`, both statistics counters are 0.
  - `stall_decode = 0`, `flush_*` follow `redirect`, `issue` follows `id_valid & ~redirect`.
- Reset mid-operation drops all pending entries immediately, with no wait for a clock edge.
- Back-to-back dependent pair, `FWD_EN=0`: `WB_DIST` stall cycles.
- Load-use pair, `FWD_EN=1`: exactly 1 stall cycle.
- Simultaneous events in one cycle:
  - An entry reaching 0 and a consumer in decode: the consumer sees the registered value, so it stalls that cycle and issues the next.
  - Issue to r and a decrement of r: the issue wins.

## Structure

- Shared package/header `hazard_pkg` holds the defaults `WB_DIST_DEF=3` and `NUM_REGS_DEF=8`, plus the `R7` link-register constant used by decode when it drives `id_dst`.
- One natural sub-module, `hazard_sb_entry`: per-register counter and load flag, with set/decrement logic. It exposes `busy` and `in_ex` (`cnt == WB_DIST`). Instantiate it `NUM_REGS` times in a generate loop.
- Top level holds the source mux, stall/flush logic and statistics counters.

## Test plan

- `FWD_EN=0`, `WB_DIST=3`: `add r1` issues at cycle 0, then `add r2,r1,r3` sits in decode → `stall_decode` high cycles 1–3, `issue` at cycle 4, `stall_cnt=3`.
- `FWD_EN=1`: `ld r4` then `add r5,r4,r4` → exactly 1 stall cycle. Repeat with `add r4` as producer → 0 stalls.
- `FWD_EN=1`: `jal` (dst 7) then `jr r7` with src0_early → 3 stall cycles; `busy_mask[7]` clears on the issue cycle.
- `redirect` asserted while decode is stalled on r1 → `flush_fetch=flush_decode=1`, `stall_decode=0`, `issue=0`, scoreboard unchanged, `flush_cnt=1`.
- WAW: `ld r2` issued, then next cycle `add r2` issued → `ld[2]=0`, `cnt[2]=3`; a following `FWD_EN=1` consumer of r2 does not stall.
- Assert `rst` asynchronously with `busy_mask=8'hFF` → all outputs at reset values before the next edge. Force `PERF_W=4` with 20 stall cycles → `stall_cnt` saturates at 15.
